_piso_register32: RTL and testbench

Parallel-in, serial-out 32-bit shift register that takes a word from a 32-bit register stage and emits it one bit per clock. It reads the `q` bus of the existing `_register32` stage through a load/ready handshake and drives a serial line with a valid qualifier and an end-of-word pulse. It is the read/serialize end of the parallel capture path and feeds the team's serial links and traffic-controller debug port.

---
 rtl/piso_pkg.sv | 18 +
 rtl/_bit_counter.sv | 30 +++
 rtl/_piso_register32.sv | 104 ++++++++++
 tb/tb__piso_register32.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out shifter: state encoding,
// default word width and the bit-counter width helper.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Wide enough to hold WIDTH itself, which is the terminal value when the
  // parity cycle is present.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/_bit_counter.sv
// Synchronous up-counter with clear, enable and a terminal-count flag used to
// mark the final serial bit of a word.
module _bit_counter
  import piso_pkg::*;
#(
  parameter int CW   = cnt_width(DEFAULT_WIDTH),
  parameter int TERM = DEFAULT_WIDTH - 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  localparam logic [CW-1:0] TERM_C = CW'(TERM);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign terminal = (count == TERM_C);

endmodule

// File: rtl/_piso_register32.sv
// Parallel-in, serial-out shift register fed from the _register32 q bus.
// Define PISO_PARITY_EN to append an even-parity bit after each word.
module _piso_register32
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int TERM = WIDTH;
`else
  localparam int TERM = WIDTH - 1;
`endif
  localparam int CW = cnt_width(WIDTH);

  // Handshake: a word transfers on any rising edge where load && ready.
  // ready depends only on state and counter, so load may be held high; it is
  // simply ignored while ready is low and d is not re-sampled.
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sr;
  logic             terminal;
  logic             last;
  logic             accept;
  logic             head;
  logic             sout_bit;

  assign last   = (state == SHIFT) && terminal;
  assign ready  = (state == IDLE) || last;
  assign accept = load && ready;

  _bit_counter #(
    .CW   (CW),
    .TERM (TERM)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept || last),
    .en       (state == SHIFT),
    .terminal (terminal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last) state_next = accept ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (accept) begin
      sr <= d;
    end else if (state == SHIFT) begin
      if (MSB_FIRST) sr <= {sr[WIDTH-2:0], 1'b0};
      else           sr <= {1'b0, sr[WIDTH-1:1]};
    end
  end

  assign head = MSB_FIRST ? sr[WIDTH-1] : sr[0];

`ifdef PISO_PARITY_EN
  logic parity;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= ^d;
    end
  end

  // The terminal count only occurs in the trailing parity cycle here.
  assign sout_bit = terminal ? parity : head;
`else
  assign sout_bit = head;
`endif

  assign sout_valid = (state == SHIFT);
  assign sout       = (state == SHIFT) && sout_bit;
  assign done       = last;

endmodule

// File: tb/tb__piso_register32.sv
// Directed bench for _piso_register32: reset, single word, back-to-back
// streaming, ignored load, mid-word reset and the (optional) parity bit.
module tb__piso_register32;

  localparam int W = 32;
`ifdef PISO_PARITY_EN
  localparam int WL = W + 1;
`else
  localparam int WL = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] d;
  logic         ready;
  logic         sout;
  logic         sout_valid;
  logic         done;

  int           checks   = 0;
  int           failures = 0;
  logic [0:0]   exp_q[$];

  always #5 clk = ~clk;

  _piso_register32 dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .d          (d),
    .ready      (ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, sout_valid, 1'b0);
    check({tag, "_sout"},  sout,       1'b0);
    check({tag, "_done"},  done,       1'b0);
    check({tag, "_ready"}, ready,      1'b1);
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int p = 0; p < W; p++) exp_q.push_back(w[W-1-p]);
    if (WL > W) exp_q.push_back(^w);
  endtask

  // Called at the first serial cycle of w. pulse_at: cycle at which a
  // foreign load is pulsed; abort_at: cycle at which rst is asserted.
  task automatic drain_word(input string tag, input logic [W-1:0] w,
                            input int pulse_at, input int abort_at);
    logic [0:0] b;
    push_word(w);
    for (int p = 0; p < WL; p++) begin
      b = exp_q.pop_front();
      check($sformatf("%s_valid%0d", tag, p + 1), sout_valid, 1'b1);
      check($sformatf("%s_sout%0d",  tag, p + 1), sout,       b);
      check($sformatf("%s_done%0d",  tag, p + 1), done,       p == WL - 1);
      check($sformatf("%s_ready%0d", tag, p + 1), ready,      p == WL - 1);
      if (p + 1 == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle({tag, "_abort"});
        exp_q.delete();
        return;
      end
      if (p + 1 == pulse_at) begin
        load = 1'b1;
        d    = 32'hFFFF_FFFF;
        step();
        load = 1'b0;
      end else begin
        step();
      end
    end
  endtask

  initial begin
    // Reset wins over a simultaneous load.
    rst  = 1'b1;
    load = 1'b1;
    d    = 32'hFFFF_FFFF;
    step();
    check_idle("rst0");
    step();
    check_idle("rst1");
    rst  = 1'b0;
    load = 1'b0;
    d    = '0;
    step();
    check_idle("idle");

    d    = 32'h0000_FFFF;
    load = 1'b1;
    step();
    load = 1'b0;
    drain_word("single", 32'h0000_FFFF, 0, 0);
    check_idle("single_end");

    // load stays high across word A; B is taken on A's last cycle.
    d    = 32'hFFFF_0000;
    load = 1'b1;
    step();
    d    = 32'h135F_A562;
    drain_word("b2b_a", 32'hFFFF_0000, 0, 0);
    load = 1'b0;
    drain_word("b2b_b", 32'h135F_A562, 0, 0);
    check_idle("b2b_end");

    d    = 32'h3561_4642;
    load = 1'b1;
    step();
    load = 1'b0;
    drain_word("ign", 32'h3561_4642, 10, 0);
    check_idle("ign_end");

    d    = 32'h135F_A562;
    load = 1'b1;
    step();
    load = 1'b0;
    drain_word("abort", 32'h135F_A562, 0, 12);
    step();
    check_idle("abort_after");

    d    = 32'h0000_0007;
    load = 1'b1;
    step();
    load = 1'b0;
    drain_word("par", 32'h0000_0007, 0, 0);
    check_idle("par_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
